reg_op_sequencer: RTL

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/gpp_seq_pkg.sv | 27 ++
 rtl/reg_op_sequencer_timeout.sv | 27 ++
 rtl/reg_op_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gpp_seq_pkg.sv
// Shared types for the register-operation sequencer: opcodes, FSM states and
// the default wait-state limit used when REG_OP_TIMEOUT_EN is defined.
package gpp_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDR = 3'd1,
        OP_LDA = 3'd2,
        OP_ALU = 3'd3,
        OP_RDR = 3'd4
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_REG    = 4'd1,
        ST_MEM_WAIT  = 4'd2,
        ST_ACC_WR    = 4'd3,
        ST_ALU_START = 4'd4,
        ST_ALU_WAIT  = 4'd5,
        ST_ALU_SAVE  = 4'd6,
        ST_RD_OUT    = 4'd7,
        ST_ERR       = 4'd8
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/reg_op_sequencer_timeout.sv
// Wait-state watchdog for the sequencer; only instantiated when REG_OP_TIMEOUT_EN is defined.
module op_timeout_counter #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // count holds the number of wait cycles already spent, so the current cycle is count+1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && (count == (LIMIT - 8'd1));

endmodule

// File: rtl/reg_op_sequencer.sv
// Register-operation sequencer: turns NOP/LDR/LDA/ALU/RDR commands into register-file strobes.
// Define REG_OP_TIMEOUT_EN to bound the memory and ALU wait states by TIMEOUT_CYCLES.
module reg_op_sequencer
    import gpp_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_sel,
    output logic       mem_rd_req,
    input  logic       mem_rd_ack,
    output logic       alu_start,
    input  logic       alu_done,
    output logic       reg_write_x,
    output logic       reg_write_y,
    output logic       reg_write_accumulator,
    output logic       reg_read_x,
    output logic       reg_read_y,
    output logic       signal_save_after_alu,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] IDLE      = ST_IDLE;
    localparam logic [3:0] WR_REG    = ST_WR_REG;
    localparam logic [3:0] MEM_WAIT  = ST_MEM_WAIT;
    localparam logic [3:0] ACC_WR    = ST_ACC_WR;
    localparam logic [3:0] ALU_START = ST_ALU_START;
    localparam logic [3:0] ALU_WAIT  = ST_ALU_WAIT;
    localparam logic [3:0] ALU_SAVE  = ST_ALU_SAVE;
    localparam logic [3:0] RD_OUT    = ST_RD_OUT;
    localparam logic [3:0] ERR       = ST_ERR;

    logic [3:0] state;
    logic [3:0] state_next;
    logic       op_sel;
    logic       nop_done;
    logic       accept;
    logic       timeout;
    logic       reading;

    assign accept = cmd_valid && cmd_ready;

`ifdef REG_OP_TIMEOUT_EN
    logic waiting;

    assign waiting = (state == MEM_WAIT) || (state == ALU_WAIT);

    op_timeout_counter #(
        .LIMIT(8'(TIMEOUT_CYCLES))
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .enable (waiting),
        .expired(timeout)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
`endif

    // an acknowledge arriving in the last allowed wait cycle still wins over the timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP:  state_next = IDLE;
                        OP_LDR:  state_next = WR_REG;
                        OP_LDA:  state_next = MEM_WAIT;
                        OP_ALU:  state_next = ALU_START;
                        OP_RDR:  state_next = RD_OUT;
                        default: state_next = ERR;
                    endcase
                end
            end
            MEM_WAIT: begin
                if (mem_rd_ack) begin
                    state_next = ACC_WR;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            ALU_START: state_next = ALU_WAIT;
            ALU_WAIT: begin
                if (alu_done) begin
                    state_next = ALU_SAVE;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_sel   <= 1'b0;
            nop_done <= 1'b0;
        end else begin
            state    <= state_next;
            nop_done <= accept && (cmd_op == OP_NOP);
            if (accept) begin
                op_sel <= cmd_sel;
            end
        end
    end

    // NOP never leaves IDLE, so its completion comes from a registered flag rather than a state
    assign cmd_ready = rst && (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = nop_done || (state == WR_REG) || (state == ACC_WR)
                    || (state == ALU_SAVE) || (state == RD_OUT);
    assign err       = (state == ERR);

    assign mem_rd_req            = (state == MEM_WAIT);
    assign alu_start             = (state == ALU_START);
    assign reg_write_x           = (state == WR_REG) && !op_sel;
    assign reg_write_y           = (state == WR_REG) && op_sel;
    assign reg_write_accumulator = (state == ACC_WR);
    assign signal_save_after_alu = (state == ALU_SAVE);

    assign reading    = (state == ALU_START) || (state == ALU_WAIT) || (state == RD_OUT);
    assign reg_read_x = reading && !op_sel;
    assign reg_read_y = reading && op_sel;

endmodule
